// File: rtl/ct_split.sv
// ct_split: one-to-many packet splitter/multicaster.
// A single staging register holds the current beat; each destination selected
// by the packet's first-beat mask must take the beat once before the staging
// register is released. The mask is held for the whole packet.
module ct_split #(
  parameter int NO    = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_eop,
  input  logic [NO-1:0]    i_mask,
  output logic [WIDTH-1:0] o_data,
  output logic             o_eop,
  output logic [NO-1:0]    o_valid,
  input  logic [NO-1:0]    i_ready
);

  logic             r_stg_valid;
  logic [WIDTH-1:0] r_stg_data;
  logic             r_stg_eop;
  logic [NO-1:0]    r_pending;
  logic [NO-1:0]    r_pkt_mask;
  logic             r_in_sop;

  logic             w_done;
  logic             w_load;

  // Beat is finished once every still-pending destination accepts this cycle.
  // A zero pending set (dropped packet) completes immediately.
  always_comb begin
    w_done  = r_stg_valid && ((r_pending & ~i_ready) == '0);
    o_ready = !r_stg_valid || w_done;
    w_load  = i_valid && o_ready;
    o_valid = {NO{r_stg_valid}} & r_pending;
    o_data  = r_stg_data;
    o_eop   = r_stg_eop;
  end

  // Staging register, per-destination pending bits and packet mask tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
      r_stg_eop   <= 1'b0;
      r_pending   <= '0;
      r_pkt_mask  <= '0;
      r_in_sop    <= 1'b1;
    end else if (w_load) begin
      r_stg_valid <= 1'b1;
      r_stg_data  <= i_data;
      r_stg_eop   <= i_eop;
      r_in_sop    <= i_eop;
      if (r_in_sop) begin
        r_pkt_mask <= i_mask;
        r_pending  <= i_mask;
      end else begin
        r_pending  <= r_pkt_mask;
      end
    end else if (w_done) begin
      r_stg_valid <= 1'b0;
      r_pending   <= '0;
    end else if (r_stg_valid) begin
      // Destinations that took the beat drop out; the rest keep seeing it.
      r_pending   <= r_pending & ~i_ready;
    end
  end

endmodule
